// File: rtl/dds_pkg.sv
// dds_pkg: shared types and constants for the DDS output path.
// DAC command-frame fields and the SPI transmitter state type.
package dds_pkg;

  localparam logic CH_A   = 1'b0;
  localparam logic CH_B   = 1'b1;
  localparam logic BUF    = 1'b0;
  localparam logic GA_N   = 1'b1;
  localparam logic SHDN_N = 1'b1;

  localparam int FRAME_W = 16;
  localparam int DAC_DW  = 12;

  typedef enum logic [2:0] {
    IDLE,
    FRAME_A,
    GAP,
    FRAME_B,
    LATCH,
    DONE
  } dac_tx_state_t;

  // Assemble one command word: {ch, BUF, GA_n, SHDN_n, data}.
  function automatic logic [FRAME_W-1:0] dac_frame(
    input logic              ch,
    input logic [DAC_DW-1:0] data
  );
    return {ch, BUF, GA_N, SHDN_N, data};
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: SCLK half-period divider for dac_spi_tx.
// clr restarts the count so the first tick is CLK_DIV cycles later.
module spi_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count down to zero, reload on every half-period boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = RELOAD;
    end else if (en) begin
      if (cnt_q == '0) begin
        cnt_d = RELOAD;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Divider count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: sends two 16-bit MCP4922-style frames, then pulses LDAC.
// Define DAC_SPI_TX_SIGNED_EN for two's-complement sample inputs.
module dac_spi_tx
  import dds_pkg::*;
#(
  parameter int DW      = 12,
  parameter int CLK_DIV = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] sample_a,
  input  logic [DW-1:0] sample_b,
  output logic          busy,
  output logic          done,
  output logic          sclk,
  output logic          mosi,
  output logic          cs_n,
  output logic          ldac_n
);

  localparam int SW = 2 * FRAME_W;

  dac_tx_state_t state_q, state_d;

  logic [SW-1:0] sh_q, sh_d;
  logic [3:0]    bit_q, bit_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          cs_n_q, cs_n_d;
  logic          ldac_n_q, ldac_n_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          tick;
  logic          accept;
  logic          tick_en;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;

`ifdef DAC_SPI_TX_SIGNED_EN
  assign data_a = {~sample_a[DW-1], sample_a[DW-2:0]};
  assign data_b = {~sample_b[DW-1], sample_b[DW-2:0]};
`else
  assign data_a = sample_a;
  assign data_b = sample_b;
`endif

  assign accept = start &&
                  (state_q == IDLE || state_q == DONE);
  assign tick_en = (state_q != IDLE) &&
                   (state_q != DONE);

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (tick_en),
    .tick (tick)
  );

  // Next-state and output logic; all outputs come from flops.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    ldac_n_d = ldac_n_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          state_d = FRAME_A;
          sh_d    = {dac_frame(CH_A, data_a),
                     dac_frame(CH_B, data_b)};
          mosi_d  = sh_d[SW-1];
          bit_d   = 4'd15;
          sclk_d  = 1'b0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      FRAME_A, FRAME_B: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            sh_d   = sh_q << 1;
            if (bit_q == 4'd0) begin
              cs_n_d = 1'b1;
              mosi_d = 1'b0;
              if (state_q == FRAME_A) begin
                state_d = GAP;
              end else begin
                state_d  = LATCH;
                ldac_n_d = 1'b0;
              end
            end else begin
              bit_d  = bit_q - 1'b1;
              mosi_d = sh_q[SW-2];
            end
          end
        end
      end
      GAP: begin
        if (tick) begin
          state_d = FRAME_B;
          cs_n_d  = 1'b0;
          bit_d   = 4'd15;
          mosi_d  = sh_q[SW-1];
        end
      end
      LATCH: begin
        if (tick) begin
          state_d  = DONE;
          ldac_n_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shifter and output registers; reset aborts any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      bit_q    <= 4'd0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      ldac_n_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      ldac_n_q <= ldac_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign sclk   = sclk_q;
  assign mosi   = mosi_q;
  assign cs_n   = cs_n_q;
  assign ldac_n = ldac_n_q;

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial transmitter that drives the DDS voice outputs to an external dual-channel 12-bit SPI DAC (MCP4922-style command frame). Sits after the voice sample outputs: on a start request it captures one sample per channel, shifts two 16-bit frames out MSB-first, then pulses LDAC so both analog outputs update together. It is the output-side counterpart of the parallel tuning-word input path.

## Interface
- `DW`, 12: sample width; fixed at 12 by the frame format.
- `CLK_DIV`, 2: SCLK half-period in `clk` cycles; legal range 1..255.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `start`  in  1  request to capture and send both samples; sampled only when `busy`=0.
- `sample_a`  in  DW  channel A sample, captured on the accepted `start` edge.
- `sample_b`  in  DW  channel B sample, captured on the accepted `start` edge.
- `busy`  out  1  high from the cycle after acceptance until completion.
- `done`  out  1  single-cycle completion pulse.
- `sclk`  out  1  SPI clock, idles low.
- `mosi`  out  1  SPI data; changes when `sclk` falls, DAC samples on the rising edge.
- `cs_n`  out  1  chip select, active low, one assertion per frame.
- `ldac_n`  out  1  latch strobe, active low.

## Operation
- Frame, bit 15 to bit 0: channel select (A=0, B=1), BUF=0, GA_n=1, SHDN_n=1, data[11:0]. Frame A = {4'h3, data_a}; frame B = {4'hB, data_b}.
- FSM states: IDLE, FRAME_A, GAP, FRAME_B, LATCH, DONE.
  - IDLE -> FRAME_A on `start`=1. Both samples are latched into internal registers on that edge.
  - FRAME_A -> GAP after 16 bits.
  - GAP -> FRAME_B after CLK_DIV cycles.
  - FRAME_B -> LATCH after 16 bits.
  - LATCH -> DONE after CLK_DIV cycles.
  - DONE -> IDLE after 1 cycle.
- `start` while `busy`=1 is ignored; there is no queueing.
- Sample inputs may change freely after acceptance.
- Bit counter is 4 bits and counts 15 down to 0.
- Divider counter is $clog2(CLK_DIV+1) bits, reloaded at every half-period.
- Reset values, and the state immediately on `rst_n` falling, including mid-frame: state IDLE, `cs_n`=1, `ldac_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0.
- A frame aborted by reset is not resumed.

## Timing
- D = CLK_DIV. Cycle 0 is the rising edge on which `start` is accepted.
- Cycles 1..32D: `cs_n`=0 and `busy`=1.
  - `mosi` presents frame A bit 15 from cycle 1.
  - For bit k (0-based from the MSB), `sclk` is high during cycles 1+(2k+1)D .. (2k+2)D.
  - The next bit is presented on the same edge that `sclk` falls.
- Cycle 32D: `sclk` ends low and the frame ends.
- Cycles 32D+1..33D: `cs_n`=1 (gap).
- Cycles 33D+1..65D: frame B, with the same bit timing.
- Cycles 65D+1..66D: `ldac_n`=0.
- Cycle 66D+1: `done`=1 and `busy`=0.
- A `start` during the `done` cycle is accepted, so back-to-back transfers run with a period of 66D+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `DAC_SPI_TX_SIGNED_EN` defined: samples are two's complement, matching the signed DDS sine output. They are converted to offset binary by inverting bit DW-1 at capture.
- Not defined: samples pass through unchanged as unsigned offset binary.

## Structure
- Shared package `dds_pkg` holds:
  - frame constants: CH_A=1'b0, CH_B=1'b1, BUF=1'b0, GA_N=1'b1, SHDN_N=1'b1, FRAME_W=16;
  - the `dac_tx_state_t` enum.
- One sub-module, `spi_tick_gen`: a CLK_DIV divider that emits a one-cycle half-period tick.
  - It is cleared on a transfer start so that the first tick lands D cycles after `cs_n` falls.
- The shift register, FSM and frame assembly live in `dac_spi_tx`.

## Test plan
- Basic transfer: D=2, macro off, `sample_a`=12'hABC, `sample_b`=12'h123 -> decoded frames 16'h3ABC then 16'hB123; `ldac_n` low for cycles 131..132; `done` at cycle 133.
- Signed conversion: macro on, `sample_a`=12'h800, `sample_b`=12'h7FF -> data fields 12'h000 and 12'hFFF.
- Fast divider: D=1, back-to-back, second `start` asserted in the `done` cycle -> `cs_n` falls at cycle 68; 16 `sclk` rising edges per frame; `mosi` stable at every rising edge.
- Busy rejection: `start` held high and sample inputs changed during FRAME_A -> frames carry the original samples, `done` pulses exactly once per accepted start, and the request held into the `done` cycle is accepted as a new transfer.
- Reset mid-frame: `rst_n` low at cycle 20 with D=2 -> all outputs at reset values asynchronously; after release, a new transfer is bit-exact.
- Gap check: `cs_n` high for exactly D cycles between frames, with `sclk`=0 throughout, for D=1, 2 and 7.
